// File: rtl/scarv_cop_palu_shift_arb.sv
// Two-requester arbiter for a shared combinational packed shifter.
// Requests are accepted in IDLE, the shifter is driven for one EXEC
// cycle, and the result is held in RESP until the consumer accepts it.
// Optional feature macro: SCARV_COP_SHIFT_ARB_RR_EN selects round-robin
// arbitration; when undefined requester 0 has fixed priority.
module scarv_cop_palu_shift_arb (
    input  logic        g_clk,
    input  logic        g_reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [5:0]  req0_shamt,
    input  logic [2:0]  req0_pw,
    input  logic        req0_sl,
    input  logic        req0_r,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [5:0]  req1_shamt,
    input  logic [2:0]  req1_pw,
    input  logic        req1_sl,
    input  logic        req1_r,

    output logic [31:0] shf_a,
    output logic [5:0]  shf_shamt,
    output logic [2:0]  shf_pw,
    output logic        shf_sl,
    output logic        shf_r,
    input  logic [31:0] shf_c,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_c,
    output logic        rsp_id,
    output logic        rsp_err,
    output logic        busy
);

    // Pack width encodings (number of lanes in the 32-bit word).
    localparam logic [2:0] PW_1  = 3'b000;
    localparam logic [2:0] PW_2  = 3'b001;
    localparam logic [2:0] PW_4  = 3'b010;
    localparam logic [2:0] PW_8  = 3'b011;
    localparam logic [2:0] PW_16 = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    function automatic logic pw_illegal(input logic [2:0] pw);
        logic bad;
        case (pw)
            PW_1, PW_2, PW_4, PW_8, PW_16: bad = 1'b0;
            default:                       bad = 1'b1;
        endcase
        return bad;
    endfunction

    state_t      state_q,     state_d;
    logic [31:0] shf_a_q,     shf_a_d;
    logic [5:0]  shf_shamt_q, shf_shamt_d;
    logic [2:0]  shf_pw_q,    shf_pw_d;
    logic        shf_sl_q,    shf_sl_d;
    logic        shf_r_q,     shf_r_d;
    logic        id_q,        id_d;
    logic [31:0] rsp_c_q,     rsp_c_d;
    logic        rsp_err_q,   rsp_err_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        busy_q,      busy_d;
`ifdef SCARV_COP_SHIFT_ARB_RR_EN
    logic        ptr_q,       ptr_d;
`endif

    logic        grant0;
    logic        grant1;

    // Arbitration: only in IDLE, only toward a requester whose valid is high.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == ST_IDLE) begin
`ifdef SCARV_COP_SHIFT_ARB_RR_EN
            if (req0_valid && (!req1_valid || !ptr_q)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end else begin
                grant0 = 1'b0;
            end
`else
            if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end else begin
                grant0 = 1'b0;
            end
`endif
        end else begin
            grant0 = 1'b0;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Next-state and datapath register updates for the IDLE/EXEC/RESP FSM.
    always_comb begin
        state_d     = state_q;
        shf_a_d     = shf_a_q;
        shf_shamt_d = shf_shamt_q;
        shf_pw_d    = shf_pw_q;
        shf_sl_d    = shf_sl_q;
        shf_r_d     = shf_r_q;
        id_d        = id_q;
        rsp_c_d     = rsp_c_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
`ifdef SCARV_COP_SHIFT_ARB_RR_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant0 || grant1) begin
                    // The shifter operand flops double as the operand store;
                    // they only reach the shifter while in EXEC.
                    shf_a_d     = grant1 ? req1_a     : req0_a;
                    shf_shamt_d = grant1 ? req1_shamt : req0_shamt;
                    shf_pw_d    = grant1 ? req1_pw    : req0_pw;
                    shf_sl_d    = grant1 ? req1_sl    : req0_sl;
                    shf_r_d     = grant1 ? req1_r     : req0_r;
                    id_d        = grant1;
                    busy_d      = 1'b1;
                    state_d     = ST_EXEC;
`ifdef SCARV_COP_SHIFT_ARB_RR_EN
                    ptr_d       = grant0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                rsp_c_d     = shf_c;
                rsp_err_d   = pw_illegal(shf_pw_q);
                rsp_valid_d = 1'b1;
                shf_a_d     = 32'h0000_0000;
                shf_shamt_d = 6'd0;
                shf_pw_d    = 3'b000;
                shf_sl_d    = 1'b0;
                shf_r_d     = 1'b0;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers; synchronous reset drops any in-flight op.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q     <= ST_IDLE;
            shf_a_q     <= 32'h0000_0000;
            shf_shamt_q <= 6'd0;
            shf_pw_q    <= 3'b000;
            shf_sl_q    <= 1'b0;
            shf_r_q     <= 1'b0;
            id_q        <= 1'b0;
            rsp_c_q     <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SCARV_COP_SHIFT_ARB_RR_EN
            ptr_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shf_a_q     <= shf_a_d;
            shf_shamt_q <= shf_shamt_d;
            shf_pw_q    <= shf_pw_d;
            shf_sl_q    <= shf_sl_d;
            shf_r_q     <= shf_r_d;
            id_q        <= id_d;
            rsp_c_q     <= rsp_c_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
`ifdef SCARV_COP_SHIFT_ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign shf_a     = shf_a_q;
    assign shf_shamt = shf_shamt_q;
    assign shf_pw    = shf_pw_q;
    assign shf_sl    = shf_sl_q;
    assign shf_r     = shf_r_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_id    = id_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_scarv_cop_palu_shift_arb.sv
// Directed bench for scarv_cop_palu_shift_arb with a behavioural packed
// shifter attached to the shf_* port.
module tb_scarv_cop_palu_shift_arb;

    localparam logic [2:0] PW_1 = 3'b000;
    localparam logic [2:0] PW_2 = 3'b001;
    localparam logic [2:0] PW_4 = 3'b010;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        req0_valid, req0_ready, req0_sl, req0_r;
    logic [31:0] req0_a;
    logic [5:0]  req0_shamt;
    logic [2:0]  req0_pw;
    logic        req1_valid, req1_ready, req1_sl, req1_r;
    logic [31:0] req1_a;
    logic [5:0]  req1_shamt;
    logic [2:0]  req1_pw;
    logic [31:0] shf_a, shf_c;
    logic [5:0]  shf_shamt;
    logic [2:0]  shf_pw;
    logic        shf_sl, shf_r;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [31:0] rsp_c;

    int n_cmp = 0;
    int n_err = 0;

    scarv_cop_palu_shift_arb dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_shamt(req0_shamt), .req0_pw(req0_pw), .req0_sl(req0_sl), .req0_r(req0_r),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_shamt(req1_shamt), .req1_pw(req1_pw), .req1_sl(req1_sl), .req1_r(req1_r),
        .shf_a(shf_a), .shf_shamt(shf_shamt), .shf_pw(shf_pw), .shf_sl(shf_sl),
        .shf_r(shf_r), .shf_c(shf_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 g_clk = ~g_clk;

    // Behavioural packed shifter: lanes of 32/n bits, illegal widths give 0.
    function automatic logic [31:0] shf_model(input logic [31:0] a, input logic [5:0] shamt,
                                              input logic [2:0] pw, input logic sl, input logic r);
        int w;
        int s;
        int base;
        int k;
        int src;
        logic [31:0] res;
        case (pw)
            3'b000:  w = 32;
            3'b001:  w = 16;
            3'b010:  w = 8;
            3'b011:  w = 4;
            3'b100:  w = 2;
            default: w = 0;
        endcase
        res = 32'h0;
        if (w != 0) begin
            for (int b = 0; b < 32; b++) begin
                base = (b / w) * w;
                k    = b - base;
                s    = int'(shamt);
                if (r) begin
                    s = s % w;
                    src = sl ? ((k - s + w) % w) : ((k + s) % w);
                    res[b] = a[base + src];
                end else if (sl) begin
                    if (k >= s) res[b] = a[base + k - s];
                end else begin
                    if (k + s < w) res[b] = a[base + k + s];
                end
            end
        end
        return res;
    endfunction

    always_comb shf_c = shf_model(shf_a, shf_shamt, shf_pw, shf_sl, shf_r);

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic drive_req(input int id, input logic [31:0] a, input logic [5:0] shamt,
                             input logic [2:0] pw, input logic sl, input logic r);
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_shamt = shamt;
            req0_pw = pw; req0_sl = sl; req0_r = r;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_shamt = shamt;
            req1_pw = pw; req1_sl = sl; req1_r = r;
        end
    endtask

    task automatic idle_reqs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_reqs();
        req0_a = 32'h0; req0_shamt = 6'd0; req0_pw = 3'b000; req0_sl = 1'b0; req0_r = 1'b0;
        req1_a = 32'h0; req1_shamt = 6'd0; req1_pw = 3'b000; req1_sl = 1'b0; req1_r = 1'b0;
        rsp_ready = 1'b1;
        g_reset = 1'b1;
        tick();
        tick();
        g_reset = 1'b0;
        n_cmp++;
        if ({rsp_valid, busy, rsp_id, rsp_err, req0_ready, req1_ready} !== 6'b000000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {rsp_valid, busy, rsp_id, rsp_err, req0_ready, req1_ready});
        end
        n_cmp++;
        if (rsp_c !== 32'h0) begin
            n_err++; $display("FAIL reset_rsp_c: got %h expected 00000000", rsp_c);
        end
        n_cmp++;
        if ({shf_a, shf_shamt, shf_pw, shf_sl, shf_r} !== 43'h0) begin
            n_err++; $display("FAIL reset_shf: got %h expected 0",
                              {shf_a, shf_shamt, shf_pw, shf_sl, shf_r});
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({busy, rsp_valid, req0_ready, req1_ready, shf_a} !== 36'h0) begin
                n_err++; $display("FAIL idle_quiet: got %h expected 0",
                                  {busy, rsp_valid, req0_ready, req1_ready, shf_a});
            end
        end
    endtask

    task automatic test_req0();
        drive_req(0, 32'h8000_0001, 6'd1, PW_1, 1'b0, 1'b1);
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_err++; $display("FAIL req0_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        tick();
        n_cmp++;
        if ({busy, rsp_valid, req0_ready, req1_ready} !== 4'b1000) begin
            n_err++; $display("FAIL req0_exec_ctrl: got %b expected 1000",
                              {busy, rsp_valid, req0_ready, req1_ready});
        end
        n_cmp++;
        if ({shf_a, shf_shamt, shf_pw, shf_sl, shf_r} !== {32'h8000_0001, 6'd1, PW_1, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL req0_exec_shf: got a=%h shamt=%0d pw=%b sl=%b r=%b expected a=80000001 shamt=1 pw=000 sl=0 r=1",
                              shf_a, shf_shamt, shf_pw, shf_sl, shf_r);
        end
        idle_reqs();
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_c, rsp_id, rsp_err} !== {1'b1, 32'hC000_0000, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL req0_resp: got v=%b c=%h id=%b err=%b expected v=1 c=c0000000 id=0 err=0",
                              rsp_valid, rsp_c, rsp_id, rsp_err);
        end
        n_cmp++;
        if (shf_a !== 32'h0) begin
            n_err++; $display("FAIL req0_shf_quiet: got %h expected 00000000", shf_a);
        end
        tick();
        n_cmp++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_err++; $display("FAIL req0_done: got %b expected 00", {rsp_valid, busy});
        end
    endtask

    task automatic test_req1();
        drive_req(1, 32'h1234_5678, 6'd4, PW_4, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_err++; $display("FAIL req1_ready: got %b expected 01", {req0_ready, req1_ready});
        end
        tick();
        idle_reqs();
        n_cmp++;
        if ({shf_shamt, shf_pw, shf_sl} !== {6'd4, PW_4, 1'b1}) begin
            n_err++; $display("FAIL req1_exec_shf: got shamt=%0d pw=%b sl=%b expected shamt=4 pw=010 sl=1",
                              shf_shamt, shf_pw, shf_sl);
        end
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_c, rsp_id, rsp_err} !== {1'b1, 32'h2040_6080, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL req1_resp: got v=%b c=%h id=%b err=%b expected v=1 c=20406080 id=1 err=0",
                              rsp_valid, rsp_c, rsp_id, rsp_err);
        end
        tick();
    endtask

    task automatic test_illegal_pw();
        drive_req(0, 32'hFFFF_FFFF, 6'd45, 3'b111, 1'b0, 1'b0);
        tick();
        idle_reqs();
        n_cmp++;
        if ({shf_shamt, shf_pw} !== {6'd45, 3'b111}) begin
            n_err++; $display("FAIL illegal_passthru: got shamt=%0d pw=%b expected shamt=45 pw=111",
                              shf_shamt, shf_pw);
        end
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_c} !== {1'b1, 1'b1, 32'h0}) begin
            n_err++; $display("FAIL illegal_resp: got v=%b err=%b c=%h expected v=1 err=1 c=00000000",
                              rsp_valid, rsp_err, rsp_c);
        end
        tick();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        drive_req(0, 32'h0000_F00F, 6'd4, PW_2, 1'b0, 1'b0);
        tick();
        idle_reqs();
        drive_req(1, 32'h0000_0100, 6'd8, PW_1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_c} !==
                {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0F00}) begin
                n_err++; $display("FAIL bp_hold: got v=%b busy=%b rdy=%b%b id=%b c=%h expected v=1 busy=1 rdy=00 id=0 c=00000f00",
                                  rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_c);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        n_cmp++;
        if ({req1_ready, busy, rsp_valid} !== 3'b100) begin
            n_err++; $display("FAIL bp_resume: got %b expected 100", {req1_ready, busy, rsp_valid});
        end
        tick();
        idle_reqs();
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_c} !== {1'b1, 1'b1, 32'h0000_0001}) begin
            n_err++; $display("FAIL bp_next: got v=%b id=%b c=%h expected v=1 id=1 c=00000001",
                              rsp_valid, rsp_id, rsp_c);
        end
        tick();
    endtask

    task automatic test_contention();
        int ng;
        int nr;
        logic [3:0] got;
        logic [3:0] exp_g;
        logic saw1;
`ifdef SCARV_COP_SHIFT_ARB_RR_EN
        exp_g = 4'b1010;
`else
        exp_g = 4'b0000;
`endif
        ng = 0; nr = 0; got = 4'b0000; saw1 = 1'b0;
        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        rsp_ready = 1'b1;
        drive_req(0, 32'h0000_0001, 6'd0, PW_1, 1'b0, 1'b0);
        drive_req(1, 32'h0000_0002, 6'd0, PW_1, 1'b0, 1'b0);
        #1;
        for (int c = 0; c < 40 && nr < 4; c++) begin
            if (req0_ready && req1_ready) begin
                n_cmp++; n_err++;
                $display("FAIL cont_both_ready: got 11 expected one-hot");
            end
            if (req1_ready) saw1 = 1'b1;
            if ((req0_ready || req1_ready) && ng < 4) begin
                got[ng] = req1_ready;
                ng++;
            end
            if (rsp_valid && nr < ng) begin
                n_cmp++;
                if ({rsp_id, rsp_c} !== {got[nr], (got[nr] ? 32'h2 : 32'h1)}) begin
                    n_err++; $display("FAIL cont_rsp: got id=%b c=%h expected id=%b c=%h",
                                      rsp_id, rsp_c, got[nr], (got[nr] ? 32'h2 : 32'h1));
                end
                nr++;
            end
            tick();
            if (ng == 4) idle_reqs();
        end
        idle_reqs();
        n_cmp++;
        if (nr !== 4) begin
            n_err++; $display("FAIL cont_count: got %0d responses expected 4", nr);
        end
        n_cmp++;
        if (got !== exp_g) begin
            n_err++; $display("FAIL cont_order: got %b expected %b (bit k = id of grant k)", got, exp_g);
        end
`ifndef SCARV_COP_SHIFT_ARB_RR_EN
        n_cmp++;
        if (saw1 !== 1'b0) begin
            n_err++; $display("FAIL cont_fixed_req1: got req1_ready seen=%b expected 0", saw1);
        end
`endif
        tick();
    endtask

    task automatic test_reset_exec();
        drive_req(0, 32'h8000_0001, 6'd1, PW_1, 1'b0, 1'b1);
        tick();
        idle_reqs();
        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        n_cmp++;
        if ({busy, rsp_valid, shf_a} !== 34'h0) begin
            n_err++; $display("FAIL rst_exec: got busy=%b v=%b shf_a=%h expected 0 0 0",
                              busy, rsp_valid, shf_a);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (rsp_valid !== 1'b0) begin
                n_err++; $display("FAIL rst_no_rsp: got %b expected 0", rsp_valid);
            end
        end
        drive_req(0, 32'h8000_0001, 6'd1, PW_1, 1'b0, 1'b1);
        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        idle_reqs();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL rst_vs_hs: got busy=%b expected 0", busy);
        end
        drive_req(1, 32'h1234_5678, 6'd4, PW_4, 1'b1, 1'b0);
        tick();
        idle_reqs();
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_c} !== {1'b1, 1'b1, 32'h2040_6080}) begin
            n_err++; $display("FAIL rst_fresh: got v=%b id=%b c=%h expected v=1 id=1 c=20406080",
                              rsp_valid, rsp_id, rsp_c);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_idle();
        test_req0();
        test_req1();
        test_illegal_pw();
        test_backpressure();
        test_contention();
        test_reset_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scarv_cop_palu_shift_arb.md
SCARV_COP_PALU_SHIFT_ARB -- requirements
Module: scarv_cop_palu_shift_arb

Interface
REQ-001 SHALL have no parameters; lane widths follow the pack-width constants in scarv_cop_common.vh.
REQ-002 g_clk  in  1  single clock; all state changes on its rising edge.
REQ-003 g_reset  in  1  synchronous, active-high reset.
REQ-004 req0_valid/req0_ready  in/out  1/1  requester 0 (coprocessor issue) handshake.
REQ-005 req0_a, req0_shamt, req0_pw, req0_sl, req0_r  in  32,6,3,1,1  requester 0 operands: LHS, shift amount, pack width, shift left, rotate.
REQ-006 req1_valid/req1_ready, req1_a, req1_shamt, req1_pw, req1_sl, req1_r  same widths  requester 1 (secondary unit), same meanings.
REQ-007 shf_a, shf_shamt, shf_pw, shf_sl, shf_r  out  32,6,3,1,1  operands to the shared combinational packed shifter.
REQ-008 shf_c  in  32  shifter result.
REQ-009 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-010 rsp_c, rsp_id, rsp_err  out  32,1,1  result, source requester, illegal pack width flag.
REQ-011 busy  out  1  high in any state other than IDLE.

Function
REQ-012 FSM states SHALL be IDLE, EXEC and RESP.
REQ-013 In IDLE, req0_ready or req1_ready SHALL be high only for the granted requester when its valid is high; the other ready SHALL be low.
REQ-014 On a handshake (valid and ready) the operands and requester id SHALL be registered and the FSM SHALL go IDLE->EXEC.
REQ-015 In EXEC, shf_* SHALL equal the registered operands; at the end of the cycle shf_c SHALL be captured into rsp_c and the FSM SHALL go EXEC->RESP.
REQ-016 Outside EXEC, shf_* SHALL be driven to zero so the datapath does not toggle.
REQ-017 In RESP, rsp_valid SHALL be high and rsp_c, rsp_id and rsp_err SHALL be held stable until rsp_ready is high; RESP->IDLE on handshake.
REQ-018 Latency from request handshake to rsp_valid SHALL be exactly 2 cycles; throughput SHALL be one operation per 3 cycles when rsp_ready is held high.
REQ-019 Both ready outputs SHALL be low in EXEC and RESP; no request is accepted until the response handshake completes.
REQ-020 rsp_err SHALL be 1 when the registered pw is not one of the PW_1/2/4/8/16 codes; the captured rsp_c is passed through unchanged (zero from the shifter).
REQ-021 shamt SHALL be passed through unmodified and SHALL NOT be masked to the lane width.
REQ-022 With neither valid high in IDLE, the FSM SHALL remain in IDLE and all outputs SHALL stay at their reset values.
REQ-023 A requester's valid SHALL NOT need to remain high after its ready is low; operands are sampled only on the handshake cycle.

Reset
REQ-024 On g_reset high at a clock edge: FSM->IDLE; rsp_valid, rsp_c, rsp_id, rsp_err, busy, shf_* = 0; priority pointer -> requester 0.
REQ-025 Reset in EXEC or RESP SHALL discard the in-flight operation with no response issued.
REQ-026 Reset SHALL override a simultaneous handshake.

Configuration
REQ-027 Macro SCARV_COP_SHIFT_ARB_RR_EN: when defined, arbitration SHALL be round-robin; the pointer toggles to the other requester after each grant, so the non-granted requester wins the next contention.
REQ-028 When SCARV_COP_SHIFT_ARB_RR_EN is undefined, requester 0 SHALL always have fixed priority and the pointer register SHALL not exist.

Verification
REQ-029 Req0 only, a=0x80000001, shamt=1, pw=PW_1, sl=0, r=1, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_c=0xC0000000, rsp_id=0, rsp_err=0.
REQ-030 Req1 only, a=0x12345678, shamt=4, pw=PW_4, sl=1, r=0 -> rsp_c=0x20406080, rsp_id=1.
REQ-031 Both valid continuously for 4 ops -> with RR_EN grants 0,1,0,1; without RR_EN grants 0,0,0,0 and req1_ready is never high.
REQ-032 rsp_ready held low 5 cycles in RESP -> rsp_c and rsp_id stable, both readys low, busy=1; accept resumes the cycle after the handshake.
REQ-033 pw=3'b111 request -> rsp_err=1, rsp_c=0.
REQ-034 g_reset asserted in EXEC -> next cycle IDLE, rsp_valid=0, no response for that request; a fresh request completes normally.
